// File: rtl/enc_tx_scheduler.sv
// Two-lane transmit scheduler that shares the encoder between the ordered-set
// generator and the transport data path. It grants whole symbols only.
module enc_tx_scheduler #(
    parameter int         OS_BURST_MAX = 4,
    parameter logic [7:0] PAD_BYTE     = 8'h00
) (
    input  logic       enc_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] gen_speed,
    input  logic       os_req,
    input  logic [7:0] os_lane_0,
    input  logic [7:0] os_lane_1,
    output logic       os_rd,
    input  logic       td_req,
    input  logic       td_valid,
    input  logic [7:0] td_lane_0,
    input  logic [7:0] td_lane_1,
    output logic       td_rd,
    output logic [7:0] lane_0_tx,
    output logic [7:0] lane_1_tx,
    output logic [3:0] d_sel,
    output logic       enc_en,
    output logic       sym_start,
    output logic       underrun
);

    localparam int         BW        = $clog2(OS_BURST_MAX + 1);
    localparam logic [3:0] DSEL_OS   = 4'd8;
    localparam logic [3:0] DSEL_TD   = 4'd0;
    localparam logic [3:0] DSEL_IDLE = 4'd9;

    // state   | meaning
    // ST_IDLE | no symbol in flight, arbitrate every cycle
    // ST_OS   | popping one ordered-set symbol, one byte per cycle
    // ST_TD   | popping one transport symbol, pad on td_valid gaps
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OS   = 2'd1,
        ST_TD   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_byte_idx;
    logic [3:0]    w_byte_idx_nxt;
    logic [BW-1:0] r_os_burst;
    logic [BW-1:0] w_os_burst_nxt;
    logic [1:0]    r_spd;
    logic [1:0]    w_spd_nxt;
    logic [3:0]    w_last_idx;
    logic          w_last;
    logic          w_arb;
    logic          w_issue_os;
    logic          w_issue_td;
    logic          w_burst_ok;

    always_comb begin
        case (r_spd)
            2'd2:    w_last_idx = 4'd7;
            2'd1:    w_last_idx = 4'd15;
            default: w_last_idx = 4'd0;
        endcase
    end

    assign w_last     = (r_byte_idx == w_last_idx);
    assign w_issue_os = enable && (r_state == ST_OS);
    assign w_issue_td = enable && (r_state == ST_TD);
    assign w_arb      = enable && ((r_state == ST_IDLE) || w_last);
    assign w_burst_ok = (r_os_burst < BW'(OS_BURST_MAX));

    // Strobes are gated by enable so nothing is popped from a symbol about to be dropped.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_idx_nxt = r_byte_idx;
        w_os_burst_nxt = r_os_burst;
        w_spd_nxt      = r_spd;
        os_rd          = w_issue_os;
        td_rd          = w_issue_td && td_valid;

        if (!enable) begin
            w_state_nxt    = ST_IDLE;
            w_byte_idx_nxt = 4'd0;
            w_os_burst_nxt = '0;
        end else begin
            if (r_state != ST_IDLE) begin
                w_byte_idx_nxt = w_last ? 4'd0 : r_byte_idx + 4'd1;
            end
            if (w_arb) begin
                if (os_req && (!td_req || w_burst_ok)) begin
                    w_state_nxt = ST_OS;
                    w_spd_nxt   = gen_speed;
                    if (!td_req) begin
                        w_os_burst_nxt = '0;
                    end else if (w_burst_ok) begin
                        w_os_burst_nxt = r_os_burst + 1'b1;
                    end
                end else if (td_req) begin
                    w_state_nxt    = ST_TD;
                    w_spd_nxt      = gen_speed;
                    w_os_burst_nxt = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge enc_clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_byte_idx <= 4'd0;
            r_os_burst <= '0;
            r_spd      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_os_burst <= w_os_burst_nxt;
            r_spd      <= w_spd_nxt;
        end
    end

    // Lane bytes hold their last value through IDLE and enable-low periods.
    always_ff @(posedge enc_clk) begin
        if (rst) begin
            lane_0_tx <= 8'h00;
            lane_1_tx <= 8'h00;
            d_sel     <= DSEL_IDLE;
            enc_en    <= 1'b0;
            sym_start <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            sym_start <= 1'b0;
            if (!enable) begin
                d_sel    <= DSEL_IDLE;
                enc_en   <= 1'b0;
                underrun <= 1'b0;
            end else if (w_issue_os) begin
                lane_0_tx <= os_lane_0;
                lane_1_tx <= os_lane_1;
                d_sel     <= DSEL_OS;
                enc_en    <= 1'b1;
                sym_start <= (r_byte_idx == 4'd0);
            end else if (w_issue_td) begin
                lane_0_tx <= td_valid ? td_lane_0 : PAD_BYTE;
                lane_1_tx <= td_valid ? td_lane_1 : PAD_BYTE;
                d_sel     <= DSEL_TD;
                enc_en    <= 1'b1;
                sym_start <= (r_byte_idx == 4'd0);
                if (!td_valid) begin
                    underrun <= 1'b1;
                end
            end else begin
                d_sel <= DSEL_IDLE;
            end
        end
    end

endmodule
